rd_wait_target: RTL and testbench
=================================

# rd_wait_target

Read-target stage that sits directly downstream of the read-sequencing FSM (the `rd`/`ds` producer, which consumes `ws` back). Answers each read transaction with a programmable number of wait cycles via `ws`, then presents one word from a small internal register file and advances its read pointer when the transaction completes. Also serves as the team's bus-functional target for controller bring-up.

## Interface
- `DW`, 8: data word width
- `AW`, 4: register-file address width; depth = 2^AW
- `WAIT_W`, 4: width of wait-cycle configuration
- `clk` in 1: clock, rising edge
- `rst` in 1: reset, asynchronous, active-high
- `rd` in 1: read request from controller; high for the whole transaction
- `ds` in 1: done strobe from controller; one-cycle pulse ending the transaction
- `wait_cfg` in WAIT_W: wait cycles N for the next transaction
- `wr_en` in 1: register-file write enable
- `wr_addr` in AW: write address
- `wr_data` in DW: write data
- `ws` out 1: wait-state to controller, combinational
- `rdata` out DW: read data, registered
- `rvalid` out 1: `rdata` valid
- `rd_ptr` out AW: address of the next/current read
- `abort_o` out 1: one-cycle pulse, transaction abandoned
- `txn_cnt` out 16: completed transactions (see Configuration)
- `abort_cnt` out 16: aborted transactions (see Configuration)

## Operation
- States: T_IDLE, T_WAIT, T_READY.
- `ws = rd & (state != T_READY)`; no other term.
- T_IDLE: on `rd=1`, latch `wcnt = wait_cfg`; go T_READY if `wait_cfg==0`, else T_WAIT. `wait_cfg` sampled only here; mid-transaction changes ignored. `ds` in T_IDLE ignored.
- T_WAIT: `wcnt` decrements each cycle; when `wcnt==1` go T_READY. If `rd=0` while in T_WAIT: go T_IDLE, pulse `abort_o`, `rd_ptr` unchanged.
- Entry into T_READY: `rdata <= mem[rd_ptr]`, `rvalid <= 1`.
- T_READY: `rdata` held. On `ds=1`: `rd_ptr <= rd_ptr+1` (wraps 2^AW-1 -> 0), `rvalid <= 0`, go T_IDLE. If `rd=0` and `ds=0`: treated as abort (same as T_WAIT abort, `rvalid <= 0`).
- `ds` and `rd` in the same cycle in T_READY: `ds` wins (completion), then T_IDLE re-evaluates `rd` next cycle.
- Writes: `mem[wr_addr] <= wr_data` on any cycle with `wr_en`, independent of state. A write to `rd_ptr` on the same edge that enters T_READY is not visible in `rdata` (old data captured).
- Register file not reset; contents undefined until written.

## Timing
- Reset values: state T_IDLE, `wcnt` 0, `rdata` 0, `rvalid` 0, `rd_ptr` 0, `abort_o` 0, counters 0; `ws` follows `rd` after reset.
- Cycle 0 = first cycle with `rd=1` (target T_IDLE, `ws=1`). Target reaches T_READY in cycle N+1; `ws=0` and `rvalid=1` from cycle N+1 on.
- Controller samples `ws` in cycles 1,3,5,...; first such cycle ≥ N+1 sees `ws=0`; `ds` arrives the following cycle.
- Completion: T_IDLE and new `rd_ptr` the cycle after `ds`; back-to-back transaction may start that cycle.
- `rst` mid-transaction: immediate return to reset values, no `abort_o` pulse, no counter update.

## Configuration
- `RD_WAIT_TARGET_STATS_EN` defined: `txn_cnt` increments on each completion, `abort_cnt` on each `abort_o`; both saturate at 16'hFFFF.
- Undefined: both ports present, tied to 0; no counter flops.

## Test plan
- `wait_cfg=0`, mem[0]=8'hA5, controller `start` pulse -> `ws=0` in cycle 1, `rvalid=1`/`rdata=A5` cycle 1, `ds` cycle 2, `rd_ptr=1` cycle 3.
- `wait_cfg=3`, mem[0]=8'h3C -> `ws=1` cycles 0-3, `ws=0` cycle 4, controller READ/DLY twice, `rdata=3C`, `ds` once, `txn_cnt=1` (STATS_EN).
- `wait_cfg=5`, drop `rd` in cycle 2 (controller reset) -> `abort_o` pulse one cycle, `rd_ptr` stays 0, `rvalid` never 1, `abort_cnt=1`.
- Write mem[k]=k^8'hFF for k=0..15, 17 back-to-back reads `wait_cfg=1` -> data FF,FE,...,F0, then FF again; `rd_ptr` wraps 15->0.
- Write to `rd_ptr` address on T_READY entry edge -> old value on `rdata`; next read of that address returns new value.
- Assert `rst` during T_WAIT with `wait_cfg=7` -> all outputs at reset values next cycle, `ws` tracks `rd`, no `abort_o`.

Source files
------------

// File: rtl/rd_wait_target.sv
// rd_wait_target: read target that answers each read with a programmable
// number of wait cycles on ws, then presents one word from a small register
// file and advances its read pointer when the controller strobes ds.
//
// Optional feature: define RD_WAIT_TARGET_STATS_EN to build saturating
// completion/abort counters; otherwise txn_cnt and abort_cnt are tied to 0.
//
// Handshake: ws is combinational, ws = rd & (state != T_READY). The
// controller holds rd high for the whole transaction; ds is a one-cycle
// pulse that completes it and is only honoured in T_READY. Dropping rd
// before ds abandons the transaction and pulses abort_o for one cycle.
module rd_wait_target #(
    parameter int DW     = 8,
    parameter int AW     = 4,
    parameter int WAIT_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd,
    input  logic              ds,
    input  logic [WAIT_W-1:0] wait_cfg,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DW-1:0]     wr_data,
    output logic              ws,
    output logic [DW-1:0]     rdata,
    output logic              rvalid,
    output logic [AW-1:0]     rd_ptr,
    output logic              abort_o,
    output logic [15:0]       txn_cnt,
    output logic [15:0]       abort_cnt
);

    typedef enum logic [1:0] {
        T_IDLE  = 2'd0,
        T_WAIT  = 2'd1,
        T_READY = 2'd2
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] wcnt;
    logic [DW-1:0]     mem [0:(1<<AW)-1];

    // Transaction events seen this cycle; shared by the FSM and the counters.
    logic txn_done;
    logic abort_evt;

    assign txn_done  = (state == T_READY) && ds;
    assign abort_evt = ((state == T_WAIT) && !rd) ||
                       ((state == T_READY) && !ds && !rd);

    // Wait-state back to the controller; released only once data is presented.
    assign ws = rd && (state != T_READY);

    // Register file write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Transaction FSM with registered data, valid, pointer and abort pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= T_IDLE;
            wcnt    <= '0;
            rdata   <= '0;
            rvalid  <= 1'b0;
            rd_ptr  <= '0;
            abort_o <= 1'b0;
        end else begin
            abort_o <= 1'b0;
            case (state)
                T_IDLE: begin
                    // wait_cfg is sampled only here; later changes are ignored.
                    if (rd) begin
                        wcnt <= wait_cfg;
                        if (wait_cfg == '0) begin
                            state  <= T_READY;
                            rdata  <= mem[rd_ptr];
                            rvalid <= 1'b1;
                        end else begin
                            state <= T_WAIT;
                        end
                    end
                end
                T_WAIT: begin
                    if (abort_evt) begin
                        state   <= T_IDLE;
                        abort_o <= 1'b1;
                    end else begin
                        wcnt <= wcnt - WAIT_W'(1);
                        if (wcnt == WAIT_W'(1)) begin
                            // A same-edge write to rd_ptr is not seen here.
                            state  <= T_READY;
                            rdata  <= mem[rd_ptr];
                            rvalid <= 1'b1;
                        end
                    end
                end
                T_READY: begin
                    // ds wins over a simultaneous rd; IDLE re-evaluates rd.
                    if (txn_done) begin
                        rd_ptr <= rd_ptr + AW'(1);
                        rvalid <= 1'b0;
                        state  <= T_IDLE;
                    end else if (abort_evt) begin
                        rvalid  <= 1'b0;
                        abort_o <= 1'b1;
                        state   <= T_IDLE;
                    end
                end
                default: begin
                    state  <= T_IDLE;
                    rvalid <= 1'b0;
                end
            endcase
        end
    end

`ifdef RD_WAIT_TARGET_STATS_EN
    // Saturating completion and abort counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txn_cnt   <= '0;
            abort_cnt <= '0;
        end else begin
            if (txn_done && (txn_cnt != 16'hFFFF)) begin
                txn_cnt <= txn_cnt + 16'd1;
            end
            if (abort_evt && (abort_cnt != 16'hFFFF)) begin
                abort_cnt <= abort_cnt + 16'd1;
            end
        end
    end
`else
    assign txn_cnt   = 16'h0000;
    assign abort_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_rd_wait_target.sv
// Testbench for rd_wait_target. Inputs are driven 1 time unit after the
// rising edge and outputs are sampled on the falling edge. Cycle 0 of a
// transaction is the first cycle with rd=1. Expected read data is queued
// when a read starts and popped when rvalid first rises.
module tb_rd_wait_target;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int WAIT_W = 4;

    logic              clk;
    logic              rst;
    logic              rd;
    logic              ds;
    logic [WAIT_W-1:0] wait_cfg;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              ws;
    logic [DW-1:0]     rdata;
    logic              rvalid;
    logic [AW-1:0]     rd_ptr;
    logic              abort_o;
    logic [15:0]       txn_cnt;
    logic [15:0]       abort_cnt;

    int total;
    int bad;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] model_mem [0:(1<<AW)-1];
    logic [AW-1:0] model_ptr;
    int            txn_model;
    int            abort_model;

    rd_wait_target #(.DW(DW), .AW(AW), .WAIT_W(WAIT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .rd        (rd),
        .ds        (ds),
        .wait_cfg  (wait_cfg),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .ws        (ws),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .rd_ptr    (rd_ptr),
        .abort_o   (abort_o),
        .txn_cnt   (txn_cnt),
        .abort_cnt (abort_cnt)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    // Expected counter value for the current build.
    function automatic logic [15:0] cnt_exp(input int v);
`ifdef RD_WAIT_TARGET_STATS_EN
        return 16'(v);
`else
        return 16'(v) & 16'h0000;
`endif
    endfunction

    // Reset pulse; leaves the bench at 1 unit after a rising edge.
    task automatic reset_dut();
        @(posedge clk); #1;
        rst = 1'b1;
        rd = 1'b0;
        ds = 1'b0;
        wr_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_ptr = '0;
        txn_model = 0;
        abort_model = 0;
        exp_q.delete();
    endtask

    task automatic write_mem(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
        model_mem[a] = d;
    endtask

    // One read with n wait cycles. The controller samples ws in odd cycles
    // and strobes ds the cycle after it sees ws=0. wr_cyc>=0 plants a write
    // to the current read address in that cycle. last=0 keeps rd high so the
    // next call starts back to back.
    task automatic read_txn(input int n, input bit last, input int wr_cyc,
                            input logic [DW-1:0] wr_val);
        int s;
        int ds_cyc;
        logic exp_ws;
        logic exp_rv;
        logic [DW-1:0] e;
        s = n + 1;
        if ((s % 2) == 0) s = s + 1;
        ds_cyc = s + 1;
        exp_q.push_back(model_mem[model_ptr]);
        for (int c = 0; c <= ds_cyc; c++) begin
            rd = 1'b1;
            ds = (c == ds_cyc);
            wait_cfg = (c == 0) ? WAIT_W'(n) : WAIT_W'($urandom_range(0, 15));
            wr_en = (c == wr_cyc);
            wr_addr = model_ptr;
            wr_data = wr_val;
            @(negedge clk);
            exp_ws = (c <= n);
            exp_rv = (c >= n + 1);
            total++;
            if (ws !== exp_ws) begin
                bad++;
                $display("FAIL read_ws n=%0d c=%0d got=%b want=%b", n, c, ws, exp_ws);
            end
            total++;
            if (rvalid !== exp_rv) begin
                bad++;
                $display("FAIL read_rvalid n=%0d c=%0d got=%b want=%b", n, c, rvalid, exp_rv);
            end
            total++;
            if ((rd_ptr !== model_ptr) || (abort_o !== 1'b0)) begin
                bad++;
                $display("FAIL read_ptr_abort n=%0d c=%0d got ptr=%0d abort=%b want ptr=%0d abort=0",
                         n, c, rd_ptr, abort_o, model_ptr);
            end
            if (c == n + 1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL read_data n=%0d got=%h want=<empty queue>", n, rdata);
                end else begin
                    e = exp_q.pop_front();
                    if (rdata !== e) begin
                        bad++;
                        $display("FAIL read_data n=%0d ptr=%0d got=%h want=%h", n, model_ptr, rdata, e);
                    end
                end
            end
            @(posedge clk); #1;
            if (c == wr_cyc) model_mem[model_ptr] = wr_val;
        end
        wr_en = 1'b0;
        ds = 1'b0;
        model_ptr = model_ptr + AW'(1);
        txn_model++;
        if (last) begin
            rd = 1'b0;
            @(negedge clk);
            total++;
            if ((rd_ptr !== model_ptr) || (rvalid !== 1'b0) || (ws !== 1'b0)) begin
                bad++;
                $display("FAIL read_done got ptr=%0d rvalid=%b ws=%b want ptr=%0d rvalid=0 ws=0",
                         rd_ptr, rvalid, ws, model_ptr);
            end
            total++;
            if (txn_cnt !== cnt_exp(txn_model)) begin
                bad++;
                $display("FAIL txn_cnt got=%0d want=%0d", txn_cnt, cnt_exp(txn_model));
            end
            @(posedge clk); #1;
        end
    endtask

    // Read with n wait cycles where rd drops in cycle drop_cyc without ds.
    task automatic abort_txn(input int n, input int drop_cyc);
        logic exp_ws;
        logic exp_rv;
        logic exp_ab;
        logic [DW-1:0] e;
        if (drop_cyc >= n + 1) exp_q.push_back(model_mem[model_ptr]);
        for (int c = 0; c <= drop_cyc + 2; c++) begin
            rd = (c < drop_cyc);
            ds = 1'b0;
            wait_cfg = (c == 0) ? WAIT_W'(n) : WAIT_W'($urandom_range(0, 15));
            @(negedge clk);
            exp_ws = (c < drop_cyc) && (c <= n);
            exp_rv = (c >= n + 1) && (c <= drop_cyc);
            exp_ab = (c == drop_cyc + 1);
            total++;
            if ((ws !== exp_ws) || (rvalid !== exp_rv)) begin
                bad++;
                $display("FAIL abort_ws_rvalid n=%0d c=%0d got ws=%b rvalid=%b want ws=%b rvalid=%b",
                         n, c, ws, rvalid, exp_ws, exp_rv);
            end
            total++;
            if ((abort_o !== exp_ab) || (rd_ptr !== model_ptr)) begin
                bad++;
                $display("FAIL abort_pulse n=%0d c=%0d got abort=%b ptr=%0d want abort=%b ptr=%0d",
                         n, c, abort_o, rd_ptr, exp_ab, model_ptr);
            end
            if ((c == n + 1) && (c <= drop_cyc)) begin
                total++;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
                if (rdata !== e) begin
                    bad++;
                    $display("FAIL abort_data got=%h want=%h", rdata, e);
                end
            end
            @(posedge clk); #1;
        end
        abort_model++;
        total++;
        if ((abort_cnt !== cnt_exp(abort_model)) || (txn_cnt !== cnt_exp(txn_model))) begin
            bad++;
            $display("FAIL abort_cnt got abort_cnt=%0d txn_cnt=%0d want %0d %0d",
                     abort_cnt, txn_cnt, cnt_exp(abort_model), cnt_exp(txn_model));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rd = 1'b0;
        ds = 1'b0;
        wait_cfg = '0;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        total++;
        if ((rdata !== 8'h00) || (rvalid !== 1'b0) || (rd_ptr !== 4'h0) || (abort_o !== 1'b0)) begin
            bad++;
            $display("FAIL reset_outputs got rdata=%h rvalid=%b ptr=%0d abort=%b want 00 0 0 0",
                     rdata, rvalid, rd_ptr, abort_o);
        end
        total++;
        if ((txn_cnt !== 16'h0) || (abort_cnt !== 16'h0) || (ws !== 1'b0)) begin
            bad++;
            $display("FAIL reset_cnt_ws got txn=%0d abort=%0d ws=%b want 0 0 0", txn_cnt, abort_cnt, ws);
        end
        rd = 1'b1;
        #1;
        total++;
        if (ws !== 1'b1) begin
            bad++;
            $display("FAIL reset_ws_tracks_rd got=%b want=1", ws);
        end
        rd = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_ptr = '0;
        txn_model = 0;
        abort_model = 0;
    endtask

    task automatic test_zero_wait();
        write_mem(4'h0, 8'hA5);
        read_txn(0, 1'b1, -1, 8'h00);
    endtask

    task automatic test_wait3();
        reset_dut();
        write_mem(4'h0, 8'h3C);
        read_txn(3, 1'b1, -1, 8'h00);
    endtask

    task automatic test_abort();
        reset_dut();
        abort_txn(5, 2);
        abort_txn(0, 2);
        // Target still serves a normal read after two aborts.
        read_txn(2, 1'b1, -1, 8'h00);
    endtask

    task automatic test_back_to_back();
        reset_dut();
        for (int k = 0; k < 16; k++) write_mem(AW'(k), DW'(k) ^ 8'hFF);
        for (int i = 0; i < 17; i++) read_txn(1, (i == 16), -1, 8'h00);
        for (int i = 0; i < 4; i++) read_txn(int'($urandom_range(0, 6)), (i == 3), -1, 8'h00);
    endtask

    task automatic test_write_collide();
        reset_dut();
        write_mem(4'h0, 8'h11);
        read_txn(2, 1'b1, 2, 8'h77);
        reset_dut();
        read_txn(0, 1'b1, -1, 8'h00);
    endtask

    task automatic test_rst_mid();
        reset_dut();
        write_mem(4'h0, 8'h5A);
        read_txn(0, 1'b1, -1, 8'h00);
        rd = 1'b1;
        wait_cfg = 4'd7;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (ws !== 1'b1) begin
                bad++;
                $display("FAIL rst_mid_wait_ws c=%0d got=%b want=1", c, ws);
            end
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ((rdata !== 8'h00) || (rvalid !== 1'b0) || (rd_ptr !== 4'h0) || (abort_o !== 1'b0) ||
            (ws !== 1'b1) || (txn_cnt !== 16'h0)) begin
            bad++;
            $display("FAIL rst_mid_values got rdata=%h rvalid=%b ptr=%0d abort=%b ws=%b txn=%0d want 00 0 0 0 1 0",
                     rdata, rvalid, rd_ptr, abort_o, ws, txn_cnt);
        end
        @(posedge clk); #1;
        rd = 1'b0;
        #1;
        total++;
        if (ws !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_ws_tracks_rd got=%b want=0", ws);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_ptr = '0;
        txn_model = 0;
        abort_model = 0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total++;
            if ((abort_o !== 1'b0) || (abort_cnt !== 16'h0) || (rd_ptr !== 4'h0)) begin
                bad++;
                $display("FAIL rst_mid_no_abort c=%0d got abort=%b abort_cnt=%0d ptr=%0d want 0 0 0",
                         c, abort_o, abort_cnt, rd_ptr);
            end
            @(posedge clk); #1;
        end
        read_txn(1, 1'b1, -1, 8'h00);
    endtask

    initial begin
        total = 0;
        bad = 0;
        for (int k = 0; k < 16; k++) model_mem[k] = 'x;
        test_reset();
        test_zero_wait();
        test_wait3();
        test_abort();
        test_back_to_back();
        test_write_collide();
        test_rst_mid();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d entries want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
